// File: rtl/mc_port_responder.sv
// mc_port_responder: single-port MC responder with fixed-latency qword memory and write flush
module mc_port_responder #(
    parameter int RTNCTL_WIDTH = 32,
    parameter int AW = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int STALL_MARGIN = 4,
    parameter int LAT = 8
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    mc_rq_vld,
    input  logic [2:0]              mc_rq_cmd,
    input  logic [3:0]              mc_rq_scmd,
    input  logic [1:0]              mc_rq_size,
    input  logic [47:0]             mc_rq_vadr,
    input  logic [63:0]             mc_rq_data,
    input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    input  logic                    mc_rq_flush,
    output logic                    mc_rq_stall,
    output logic                    mc_rs_vld,
    output logic [2:0]              mc_rs_cmd,
    output logic [3:0]              mc_rs_scmd,
    output logic [63:0]             mc_rs_data,
    output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    input  logic                    mc_rs_stall,
    output logic                    mc_rs_flush_cmplt,
    output logic [1:0]              err_sticky
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] STALL_THR = (PW+1)'(FIFO_DEPTH - STALL_MARGIN);

    typedef struct packed {
        logic                    wr;
        logic [AW-1:0]           idx;
        logic [63:0]             data;
        logic [RTNCTL_WIDTH-1:0] rtnctl;
        logic [15:0]             stamp;
    } entry_t;

    entry_t                  fifo [FIFO_DEPTH];
    logic [63:0]             mem [2**AW];
    logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]             cnt_q, cnt_d;
    logic [15:0]             cyc_q, cyc_d;
    logic                    stall_q, stall_d;
    logic                    rs_vld_q, rs_vld_d;
    logic [2:0]              rs_cmd_q, rs_cmd_d;
    logic [63:0]             rs_data_q, rs_data_d;
    logic [RTNCTL_WIDTH-1:0] rs_rtnctl_q, rs_rtnctl_d;
    logic                    cmplt_q, cmplt_d;
    logic [1:0]              err_q, err_d;
    logic [15:0]             wr_acc_q, wr_acc_d, wr_done_q, wr_done_d, tgt_q, tgt_d;
    logic                    pend_q, pend_d;
    logic                    legal, full, push, pop, xfer, pend_any;
    logic [15:0]             tgt_any;
    entry_t                  head;
    logic                    unused_ok;

    assign unused_ok = ^{mc_rq_scmd, mc_rq_vadr[47:AW+3], mc_rq_vadr[2:0]};

    // queue control, response register, and flush tracking next-state
    always_comb begin
        legal       = (mc_rq_cmd == 3'd1 || mc_rq_cmd == 3'd2) && mc_rq_size == 2'd3;
        full        = cnt_q == (PW+1)'(FIFO_DEPTH);
        push        = mc_rq_vld && legal && !full;
        head        = fifo[rp_q];
        xfer        = rs_vld_q && !mc_rs_stall;
        pop         = cnt_q != '0 && (cyc_q - head.stamp) >= 16'(LAT) && (!rs_vld_q || !mc_rs_stall);
        wp_d        = push ? wp_q + PW'(1) : wp_q;
        rp_d        = pop ? rp_q + PW'(1) : rp_q;
        cnt_d       = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        cyc_d       = cyc_q + 16'd1;
        stall_d     = cnt_d >= STALL_THR;
        err_d       = err_q | {mc_rq_vld && full, mc_rq_vld && !legal};
        rs_vld_d    = pop || (rs_vld_q && !xfer);
        rs_cmd_d    = pop ? (head.wr ? 3'd3 : 3'd2) : rs_cmd_q;
        rs_data_d   = pop ? (head.wr ? 64'd0 : mem[head.idx]) : rs_data_q;
        rs_rtnctl_d = pop ? head.rtnctl : rs_rtnctl_q;
        wr_acc_d    = wr_acc_q + 16'(push && mc_rq_cmd == 3'd2);
        wr_done_d   = wr_done_q + 16'(xfer && rs_cmd_q == 3'd3);
        pend_any    = pend_q || mc_rq_flush;
        tgt_any     = mc_rq_flush ? wr_acc_d : tgt_q;
        cmplt_d     = pend_any && wr_done_d == tgt_any;
        pend_d      = pend_any && !cmplt_d;
        tgt_d       = tgt_any;
    end

    // control state registers
    always_ff @(posedge clk) begin
        if (i_reset) begin
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            cyc_q       <= '0;
            stall_q     <= 1'b0;
            rs_vld_q    <= 1'b0;
            rs_cmd_q    <= '0;
            rs_data_q   <= '0;
            rs_rtnctl_q <= '0;
            cmplt_q     <= 1'b0;
            err_q       <= '0;
            wr_acc_q    <= '0;
            wr_done_q   <= '0;
            tgt_q       <= '0;
            pend_q      <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            stall_q     <= stall_d;
            rs_vld_q    <= rs_vld_d;
            rs_cmd_q    <= rs_cmd_d;
            rs_data_q   <= rs_data_d;
            rs_rtnctl_q <= rs_rtnctl_d;
            cmplt_q     <= cmplt_d;
            err_q       <= err_d;
            wr_acc_q    <= wr_acc_d;
            wr_done_q   <= wr_done_d;
            tgt_q       <= tgt_d;
            pend_q      <= pend_d;
        end
    end

    // queue storage and memory; memory survives reset but is not written while in reset
    always_ff @(posedge clk) begin
        if (push) fifo[wp_q] <= '{wr: mc_rq_cmd == 3'd2, idx: mc_rq_vadr[AW+2:3], data: mc_rq_data, rtnctl: mc_rq_rtnctl, stamp: cyc_q};
        if (!i_reset && pop && head.wr) mem[head.idx] <= head.data;
    end

    assign mc_rq_stall       = stall_q;
    assign mc_rs_vld         = rs_vld_q;
    assign mc_rs_cmd         = rs_cmd_q;
    assign mc_rs_scmd        = 4'd0;
    assign mc_rs_data        = rs_data_q;
    assign mc_rs_rtnctl      = rs_rtnctl_q;
    assign mc_rs_flush_cmplt = cmplt_q;
    assign err_sticky        = err_q;
endmodule

// File: tb/tb_mc_port_responder.sv
// tb_mc_port_responder: directed table, corner sequences and randomized model check
module tb_mc_port_responder;
    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        mc_rq_vld = 1'b0;
    logic [2:0]  mc_rq_cmd = '0;
    logic [3:0]  mc_rq_scmd = '0;
    logic [1:0]  mc_rq_size = 2'd3;
    logic [47:0] mc_rq_vadr = '0;
    logic [63:0] mc_rq_data = '0;
    logic [31:0] mc_rq_rtnctl = '0;
    logic        mc_rq_flush = 1'b0;
    logic        mc_rs_stall = 1'b0;
    logic        mc_rq_stall, mc_rs_vld, mc_rs_flush_cmplt;
    logic [2:0]  mc_rs_cmd;
    logic [3:0]  mc_rs_scmd;
    logic [63:0] mc_rs_data;
    logic [31:0] mc_rs_rtnctl;
    logic [1:0]  err_sticky;

    int checks = 0;
    int failures = 0;

    mc_port_responder dut (
        .clk(clk), .i_reset(i_reset),
        .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
        .mc_rq_size(mc_rq_size), .mc_rq_vadr(mc_rq_vadr), .mc_rq_data(mc_rq_data),
        .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
        .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
        .mc_rs_data(mc_rs_data), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall),
        .mc_rs_flush_cmplt(mc_rs_flush_cmplt), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    // reference model: request queue with absolute accept times, sparse memory, response slot
    typedef struct {
        bit          wr;
        int          idx;
        logic [63:0] data;
        logic [31:0] rtn;
        int          stamp;
    } req_t;

    req_t        q[$];
    logic [63:0] mmem [int];
    int          mcyc = 0;
    bit          m_vld = 0, m_stall = 0, m_cmplt = 0, pend = 0;
    logic [2:0]  m_cmd = '0;
    logic [63:0] m_data = '0;
    logic [31:0] m_rtn = '0;
    logic [1:0]  m_err = '0;
    int          wr_acc = 0, wr_done = 0, tgt = 0;
    logic [31:0] got_rtn[$];
    logic [63:0] got_data[$];

    function automatic void model_step();
        bit   xfer, full, legal;
        req_t h;
        if (i_reset) begin
            q.delete();
            mcyc = 0; m_vld = 0; m_cmd = 0; m_data = 0; m_rtn = 0;
            m_stall = 0; m_cmplt = 0; m_err = 0;
            wr_acc = 0; wr_done = 0; tgt = 0; pend = 0;
            return;
        end
        xfer = m_vld && !mc_rs_stall;
        if (xfer && m_cmd == 3'd3) wr_done++;
        if (xfer) m_vld = 0;
        full  = q.size() == 16;
        legal = (mc_rq_cmd == 3'd1 || mc_rq_cmd == 3'd2) && mc_rq_size == 2'd3;
        if (q.size() > 0 && !m_vld && mcyc - q[0].stamp >= 8) begin
            h = q.pop_front();
            m_vld = 1;
            m_rtn = h.rtn;
            if (h.wr) begin
                mmem[h.idx] = h.data;
                m_cmd = 3'd3;
                m_data = '0;
            end else begin
                m_cmd = 3'd2;
                m_data = mmem[h.idx];
            end
        end
        if (mc_rq_vld && !legal) m_err[0] = 1'b1;
        if (mc_rq_vld && full) m_err[1] = 1'b1;
        if (mc_rq_vld && legal && !full) begin
            q.push_back('{mc_rq_cmd == 3'd2, int'(mc_rq_vadr[12:3]), mc_rq_data, mc_rq_rtnctl, mcyc});
            if (mc_rq_cmd == 3'd2) wr_acc++;
        end
        m_stall = q.size() >= 12;
        if (mc_rq_flush) begin
            pend = 1;
            tgt = wr_acc;
        end
        m_cmplt = pend && wr_done == tgt;
        if (m_cmplt) pend = 0;
        mcyc++;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("rs_vld", mc_rs_vld, m_vld);
        chk("rq_stall", mc_rq_stall, m_stall);
        chk("flush_cmplt", mc_rs_flush_cmplt, m_cmplt);
        chk("err_sticky", err_sticky, m_err);
        chk("rs_scmd", mc_rs_scmd, 0);
        if (m_vld) begin
            chk("rs_cmd", mc_rs_cmd, m_cmd);
            chk("rs_data", mc_rs_data, m_data);
            chk("rs_rtnctl", mc_rs_rtnctl, m_rtn);
        end
    endtask

    task automatic req(input logic [2:0] cmd, input logic [1:0] size, input logic [47:0] a,
                       input logic [63:0] d, input logic [31:0] r);
        mc_rq_vld = 1'b1; mc_rq_cmd = cmd; mc_rq_size = size;
        mc_rq_vadr = a; mc_rq_data = d; mc_rq_rtnctl = r;
        step();
        mc_rq_vld = 1'b0; mc_rq_size = 2'd3;
    endtask

    task automatic do_reset();
        mc_rq_vld = 1'b0; mc_rq_flush = 1'b0; mc_rs_stall = 1'b0;
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
    endtask

    task automatic collect(input int n);
        got_rtn.delete();
        got_data.delete();
        for (int k = 0; k < n; k++) begin
            if (mc_rs_vld && !mc_rs_stall) begin
                got_rtn.push_back(mc_rs_rtnctl);
                got_data.push_back(mc_rs_data);
            end
            step();
        end
    endtask

    typedef struct {
        logic        vld;
        logic [2:0]  cmd;
        logic [47:0] vadr;
        logic [63:0] data;
        logic [31:0] rtn;
        logic        e_vld;
        logic [2:0]  e_cmd;
        logic [63:0] e_data;
        logic [31:0] e_rtn;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int pulses, pulse_t, t3, t4, first_t, last_t, held;
        logic [63:0] hd;
        logic [31:0] hr;
        logic [47:0] a;
        for (int k = 0; k < 13; k++) tbl[k] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[0]  = '{1, 3'd2, 48'h40, 64'hDEADBEEF, 32'h11, 0, 0, 0, 0};
        tbl[2]  = '{1, 3'd1, 48'h40, 64'h0, 32'h22, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 3'd3, 64'h0, 32'h11};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 3'd2, 64'hDEADBEEF, 32'h22};

        do_reset();
        chk("reset_vld", mc_rs_vld, 0);
        chk("reset_stall", mc_rq_stall, 0);
        chk("reset_cmplt", mc_rs_flush_cmplt, 0);
        chk("reset_err", err_sticky, 0);
        chk("reset_cmd", mc_rs_cmd, 0);
        chk("reset_data", mc_rs_data, 0);
        chk("reset_rtnctl", mc_rs_rtnctl, 0);

        // WR then RD: table row k drives cycle k; expectation is the following cycle
        for (int k = 0; k < 13; k++) begin
            mc_rq_vld = tbl[k].vld; mc_rq_cmd = tbl[k].cmd; mc_rq_size = 2'd3;
            mc_rq_vadr = tbl[k].vadr; mc_rq_data = tbl[k].data; mc_rq_rtnctl = tbl[k].rtn;
            step();
            chk("tbl_vld", mc_rs_vld, tbl[k].e_vld);
            if (tbl[k].e_vld) begin
                chk("tbl_cmd", mc_rs_cmd, tbl[k].e_cmd);
                chk("tbl_data", mc_rs_data, tbl[k].e_data);
                chk("tbl_rtnctl", mc_rs_rtnctl, tbl[k].e_rtn);
            end
        end
        mc_rq_vld = 1'b0;

        // fill with the consumer stalled: one pop lands in the response register
        do_reset();
        mc_rs_stall = 1'b1;
        for (int i = 0; i < 18; i++) begin
            req(3'd1, 2'd3, 48'h40, 64'h0, 32'(i));
            if (i == 11) chk("fill_stall_low", mc_rq_stall, 0);
            if (i == 12) chk("fill_stall_high", mc_rq_stall, 1);
            if (i == 16) chk("fill_no_ovf", err_sticky, 2'b00);
            if (i == 17) chk("fill_ovf", err_sticky, 2'b10);
        end
        mc_rs_stall = 1'b0;
        first_t = -1; last_t = -1;
        got_rtn.delete();
        for (int t = 0; t < 30; t++) begin
            if (mc_rs_vld) begin
                got_rtn.push_back(mc_rs_rtnctl);
                if (first_t < 0) first_t = t;
                last_t = t;
            end
            step();
        end
        chk("fill_count", got_rtn.size(), 17);
        chk("fill_b2b", last_t - first_t, 16);
        for (int i = 0; i < got_rtn.size(); i++) chk("fill_order", got_rtn[i], 32'(i));

        // first response held for 5 cycles by consumer stall
        do_reset();
        for (int i = 0; i < 3; i++) req(3'd1, 2'd3, 48'h40, 64'h0, 32'h30 + 32'(i));
        for (int k = 0; k < 20 && !mc_rs_vld; k++) step();
        chk("hold_seen", mc_rs_vld, 1);
        hd = mc_rs_data; hr = mc_rs_rtnctl;
        mc_rs_stall = 1'b1;
        held = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_vld", mc_rs_vld, 1);
            chk("hold_data", mc_rs_data, hd);
            chk("hold_rtnctl", mc_rs_rtnctl, hr);
            held++;
        end
        mc_rs_stall = 1'b0;
        collect(10);
        chk("hold_cycles", held, 5);
        chk("hold_count", got_rtn.size(), 3);
        for (int i = 0; i < got_rtn.size(); i++) chk("hold_order", got_rtn[i], 32'h30 + 32'(i));

        // flush: three writes, flush, one more write
        do_reset();
        pulses = 0; pulse_t = -1; t3 = -1; t4 = -1;
        for (int t = 0; t < 25; t++) begin
            if (mc_rs_flush_cmplt) begin
                pulses++;
                pulse_t = t;
            end
            if (mc_rs_vld && !mc_rs_stall && mc_rs_rtnctl == 32'h43) t3 = t;
            if (mc_rs_vld && !mc_rs_stall && mc_rs_rtnctl == 32'h44) t4 = t;
            mc_rq_vld = t inside {0, 1, 2, 4};
            mc_rq_cmd = 3'd2;
            mc_rq_vadr = 48'h100 + 48'(8 * t);
            mc_rq_data = 64'hF000 + 64'(t);
            mc_rq_rtnctl = t == 4 ? 32'h44 : 32'h41 + 32'(t);
            mc_rq_flush = t == 3;
            step();
        end
        mc_rq_vld = 1'b0;
        mc_rq_flush = 1'b0;
        chk("flush_pulses", pulses, 1);
        chk("flush_pulse_t", pulse_t, 12);
        chk("flush_after_3rd", t3 + 1, pulse_t);
        chk("flush_before_4th", t4 > pulse_t, 1);
        mc_rq_flush = 1'b1;
        step();
        mc_rq_flush = 1'b0;
        chk("idle_flush_pulse", mc_rs_flush_cmplt, 1);
        step();
        chk("idle_flush_once", mc_rs_flush_cmplt, 0);

        // illegal requests are dropped, a following legal one is serviced
        do_reset();
        req(3'd3, 2'd3, 48'h40, 64'h0, 32'h50);
        req(3'd1, 2'd1, 48'h40, 64'h0, 32'h51);
        req(3'd1, 2'd3, 48'h40, 64'h0, 32'h55);
        collect(15);
        chk("illegal_err", err_sticky, 2'b01);
        chk("illegal_count", got_rtn.size(), 1);
        if (got_rtn.size() > 0) begin
            chk("illegal_next_rtn", got_rtn[0], 32'h55);
            chk("illegal_next_data", got_data[0], 64'hDEADBEEF);
        end

        // reset with queued requests: nothing emerges, memory retained
        do_reset();
        for (int i = 0; i < 5; i++) req(3'd1, 2'd3, 48'h40, 64'h0, 32'h60 + 32'(i));
        step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("rst_mid_vld", mc_rs_vld, 0);
        chk("rst_mid_stall", mc_rq_stall, 0);
        collect(20);
        chk("rst_mid_none", got_rtn.size(), 0);
        req(3'd1, 2'd3, 48'h40, 64'h0, 32'h66);
        collect(15);
        chk("rst_mem_count", got_rtn.size(), 1);
        if (got_rtn.size() > 0) chk("rst_mem_data", got_data[0], 64'hDEADBEEF);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int idx;
            idx = 8 + 37 * int'($urandom_range(0, 7));
            a = {$urandom(), $urandom()};
            a[12:3] = 10'(idx);
            mc_rq_vld = $urandom_range(0, 9) < 6;
            mc_rq_cmd = ($urandom_range(0, 1) == 1 && mmem.exists(idx)) ? 3'd1 : 3'd2;
            if ($urandom_range(0, 29) == 0) mc_rq_cmd = 3'($urandom_range(0, 7));
            mc_rq_size = $urandom_range(0, 29) == 0 ? 2'($urandom_range(0, 3)) : 2'd3;
            if ((mc_rq_cmd == 3'd1 || mc_rq_cmd == 3'd2) && !mmem.exists(idx)) mc_rq_cmd = 3'd2;
            mc_rq_vadr = a;
            mc_rq_data = {$urandom(), $urandom()};
            mc_rq_rtnctl = $urandom();
            mc_rq_flush = $urandom_range(0, 32) == 0;
            mc_rs_stall = $urandom_range(0, 9) < 3;
            i_reset = $urandom_range(0, 499) == 0;
            step();
        end
        i_reset = 1'b0;
        mc_rq_vld = 1'b0;
        mc_rq_flush = 1'b0;
        mc_rs_stall = 1'b0;
        for (int n = 0; n < 40; n++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
